// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, default oversampling and baud-select codes.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int UART_SAMPLE_DEFAULT = 16;

  typedef enum logic [1:0] {
    BAUD_4800   = 2'd0,
    BAUD_9600   = 2'd1,
    BAUD_57600  = 2'd2,
    BAUD_115200 = 2'd3
  } baud_sel_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer; both stages load RESET_VAL while rst is low.
module uart_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic SysClk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge SysClk or negedge rst) begin
    if (!rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver with 16x oversampling off the toggling baud_clk.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int SAMPLE    = UART_SAMPLE_DEFAULT
) (
  input  logic                 SysClk,
  input  logic                 rst,
  input  logic                 baud_clk,
  input  logic                 rx,
  input  logic                 rx_read,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd,
  output logic                 parity_err,
`endif
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int CW = $clog2(SAMPLE);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(SAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic rx_s;
  logic baud_s;
  logic baud_dly_q;
  logic tick;

  uart_sync #(.RESET_VAL(1'b1)) u_rx_sync (
    .SysClk (SysClk),
    .rst    (rst),
    .d_i    (rx),
    .q_o    (rx_s)
  );

  uart_sync #(.RESET_VAL(1'b0)) u_baud_sync (
    .SysClk (SysClk),
    .rst    (rst),
    .d_i    (baud_clk),
    .q_o    (baud_s)
  );

  always_ff @(posedge SysClk or negedge rst) begin
    if (!rst) baud_dly_q <= 1'b0;
    else      baud_dly_q <= baud_s;
  end

  // Either edge of baud_clk is one sample tick.
  assign tick = baud_s ^ baud_dly_q;

  rx_state_t              state_q;
  logic [CW-1:0]          cnt_q;
  logic [IW-1:0]          idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   valid_q;
  logic                   frame_err_q;
  logic                   overrun_q;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad_q;
  logic                   par_err_q;
`endif

  always_ff @(posedge SysClk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      // A completing frame below overrides this clear in the same cycle.
      if (rx_read && valid_q) begin
        valid_q     <= 1'b0;
        frame_err_q <= 1'b0;
        overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_q   <= 1'b0;
`endif
      end

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rx_s) state_q <= START;
        end

        START: begin
          if (tick) begin
            if (cnt_q == CNT_HALF) begin
              cnt_q <= '0;
              idx_q <= '0;
              if (rx_s) state_q <= IDLE;
              else      state_q <= DATA;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        DATA: begin
          if (tick) begin
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
              idx_q   <= idx_q + 1'b1;
              if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (cnt_q == CNT_LAST) begin
              cnt_q     <= '0;
              par_bad_q <= rx_s ^ (^shift_q) ^ parity_odd;
              state_q   <= STOP;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
`endif

        STOP: begin
          if (tick) begin
            if (cnt_q == CNT_LAST) begin
              cnt_q       <= '0;
              data_q      <= shift_q;
              valid_q     <= 1'b1;
              frame_err_q <= ~rx_s;
              overrun_q   <= valid_q & ~rx_read;
`ifdef UART_RX_PARITY_EN
              par_err_q   <= par_bad_q;
`endif
              state_q     <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign framing_err = frame_err_q;
  assign overrun_err = overrun_q;
  assign busy        = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err  = par_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler; baud_clk toggles every 4 SysClk cycles to keep frames short.
`timescale 1ns/1ps
module tb_uart_rx_sampler;
  import uart_pkg::*;

  localparam int SAMPLE = 16;
  localparam int CLK_T  = 10;
  localparam int TICK_T = 4 * CLK_T;
  localparam int BIT_T  = SAMPLE * TICK_T;
  localparam int BOUND  = 4 * SAMPLE * 4;

  logic       SysClk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_clk = 1'b0;
  logic       rx = 1'b1;
  logic       rx_read = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       framing_err;
  logic       overrun_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_odd = 1'b0;
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;

  always #(CLK_T / 2) SysClk = ~SysClk;
  always #(TICK_T) baud_clk = ~baud_clk;

  uart_rx_sampler #(.DATA_BITS(8), .SAMPLE(SAMPLE)) dut (
    .SysClk      (SysClk),
    .rst         (rst),
    .baud_clk    (baud_clk),
    .rx          (rx),
    .rx_read     (rx_read),
`ifdef UART_RX_PARITY_EN
    .parity_odd  (parity_odd),
    .parity_err  (parity_err),
`endif
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .framing_err (framing_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_read();
    @(negedge SysClk);
    rx_read = 1'b1;
    @(posedge SysClk);
    #1 rx_read = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par_bit,
                            input logic stop_bit, input bit read_at_done);
    int n;
    rx = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      #(BIT_T);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_bit;
    #(BIT_T);
`else
    if (par_bit) n = 0;
`endif
    rx = stop_bit;
    n = 0;
    @(negedge SysClk);
    while (!(dut.state_q == STOP && dut.cnt_q == 4'(SAMPLE - 1) && dut.tick) && n < BOUND) begin
      @(negedge SysClk);
      n++;
    end
    check("frame_done", 32'(n < BOUND), 32'd1);
    if (read_at_done) rx_read = 1'b1;
    @(posedge SysClk);
    #1 rx_read = 1'b0;
    rx = 1'b1;
    repeat (2 * SAMPLE * 4) @(posedge SysClk);
    #1;
    $display("frame %02h stop %0b read %0b -> data %02h valid %0b ferr %0b oerr %0b",
             data, stop_bit, read_at_done, rx_data, rx_valid, framing_err, overrun_err);
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(posedge SysClk);
    #1;
    check("rst_data", 32'(rx_data), 32'h00);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_ferr", 32'(framing_err), 32'd0);
    check("rst_oerr", 32'(overrun_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    #3 rst = 1'b1;
    repeat (20) @(posedge SysClk);
    #1;

    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    check("good_data", 32'(rx_data), 32'hA5);
    check("good_valid", 32'(rx_valid), 32'd1);
    check("good_ferr", 32'(framing_err), 32'd0);
    check("good_oerr", 32'(overrun_err), 32'd0);
    pulse_read();
    check("read_valid", 32'(rx_valid), 32'd0);
    check("read_data", 32'(rx_data), 32'hA5);

    rx = 1'b0;
    repeat (5) @(posedge SysClk);
    #1 check("glitch_busy", 32'(busy), 32'd1);
    repeat (7) @(posedge SysClk);
    rx = 1'b1;
    repeat (20 * 4) @(posedge SysClk);
    #1;
    check("glitch_idle", 32'(busy), 32'd0);
    check("glitch_valid", 32'(rx_valid), 32'd0);
    $display("glitch 3 ticks -> busy %0b valid %0b", busy, rx_valid);

    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check("ferr_data", 32'(rx_data), 32'h3C);
    check("ferr_valid", 32'(rx_valid), 32'd1);
    check("ferr_flag", 32'(framing_err), 32'd1);
    pulse_read();
    check("ferr_clear", 32'(framing_err), 32'd0);

    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    check("ovr_data", 32'(rx_data), 32'h22);
    check("ovr_flag", 32'(overrun_err), 32'd1);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    pulse_read();
    check("ovr_clear", 32'(overrun_err), 32'd0);
    check("ovr_clear_valid", 32'(rx_valid), 32'd0);

    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1);
    check("race_data", 32'(rx_data), 32'h22);
    check("race_valid", 32'(rx_valid), 32'd1);
    check("race_oerr", 32'(overrun_err), 32'd0);

    rx = 1'b0;
    #(3 * BIT_T + 3);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data", 32'(rx_data), 32'h00);
    rx = 1'b1;
    #(4 * CLK_T) rst = 1'b1;
    #(12 * BIT_T);
    check("post_rst_valid", 32'(rx_valid), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    $display("reset mid-frame -> valid %0b busy %0b", rx_valid, busy);

`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    check("par_ok_data", 32'(rx_data), 32'h07);
    check("par_ok", 32'(parity_err), 32'd0);
    pulse_read();
    send_frame(8'h07, 1'b0, 1'b1, 1'b0);
    check("par_bad", 32'(parity_err), 32'd1);
    pulse_read();
    check("par_clear", 32'(parity_err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

UART receiver that consumes the oversampled `baud_clk` from the baud rate generator. It recovers 8N1 frames from the serial `rx` line using 16x oversampling and mid-bit sampling, and presents each byte through a valid/read handshake. It sits on the APB UART peripheral between the pad-side `rx` input and the register-interface read path, alongside the transmitter.

## Interface
Parameters:
- `DATA_BITS`, 8: data bits per frame, LSB first; legal range 5–8.
- `SAMPLE`, 16: ticks per bit; must match the generator; even, ≥ 8.

Ports:
- `SysClk`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `baud_clk`  in  1: toggling output of the baud generator; each transition (rising or falling) is one sample tick.
- `rx`  in  1: asynchronous serial input; idle high.
- `rx_read`  in  1: one-cycle pulse that consumes the current byte and clears the flags.
- `rx_data`  out  `DATA_BITS`: last received byte.
- `rx_valid`  out  1: byte available; level signal.
- `framing_err`  out  1: stop bit of the current `rx_data` frame sampled as 0.
- `overrun_err`  out  1: a frame completed while `rx_valid` was already 1.
- `busy`  out  1: high in every state except IDLE.
- `parity_odd`  in  1: parity sense (1 = odd); only with `UART_RX_PARITY_EN`.
- `parity_err`  out  1: parity mismatch; only with `UART_RX_PARITY_EN`.

## Operation
- Input conditioning:
  - `rx` passes through a 2-FF synchronizer; both stages reset to 1.
  - `baud_clk` passes through a 2-FF synchronizer (resets to 0) plus one delay flop.
  - `tick` = sync_out XOR delayed, one `SysClk` cycle wide.
- Tick counter `cnt` is `$clog2(SAMPLE)` bits wide and advances only on `tick`. Bit index `idx` is `$clog2(DATA_BITS+1)` bits wide.
- States:
  - IDLE: `cnt` = 0. Synchronized `rx` == 0 → START.
  - START: on the tick where `cnt` == `SAMPLE/2-1`:
    - `rx` == 0 → DATA, with `cnt` = 0 and `idx` = 0.
    - `rx` == 1 (glitch) → IDLE; no flag is set.
  - DATA: on the tick where `cnt` == `SAMPLE-1`:
    - Shift `rx` into the MSB of the shift register (right shift, LSB first).
    - `idx`++ and `cnt` = 0.
    - When `idx` reaches `DATA_BITS`, go to PARITY if the macro is defined, otherwise STOP.
  - PARITY: on the tick where `cnt` == `SAMPLE-1`, compare `rx` with the expected parity; → STOP.
  - STOP: on the tick where `cnt` == `SAMPLE-1`, complete the frame and return to IDLE in the same cycle.
- Frame completion:
  - `rx_data` ← shift register, `rx_valid` ← 1, `framing_err` ← (stop sample == 0).
  - `parity_err` ← mismatch (macro builds only).
  - `overrun_err` ← `rx_valid` AND NOT `rx_read` in that cycle.
  - A byte with `framing_err` is still delivered.
- `rx_read` with no completion in the same cycle: clears `rx_valid`, `framing_err`, `overrun_err` and `parity_err`. `rx_read` while `rx_valid` == 0 has no effect.
- Completion and `rx_read` in the same cycle: completion wins. `rx_valid` stays 1, the flags take the new frame's values, and `overrun_err` = 0.
- Overrun: the new byte overwrites the old one.
- A stop bit of 0 (break) followed by `rx` staying low re-enters START from IDLE on the next cycle.

## Timing
- Reset values: `rx_data` = 0; `rx_valid`, `framing_err`, `overrun_err`, `parity_err`, `busy` = 0; state = IDLE.
- Reset is asynchronous and takes effect immediately, including mid-frame. The partial frame is discarded and no flags are set.
- Latency from the `rx` falling edge to leaving IDLE: 2 cycles (synchronizer) + 1.
- Latency from the `baud_clk` transition to `tick`: 3 cycles.
- `rx_valid` rises in the cycle after the stop-bit sampling tick.
- A frame occupies (1 + `DATA_BITS` [+1] + 1) × `SAMPLE` ticks. Stop-bit sampling ends half a bit early, giving a half-bit resynchronization margin.
- Changing `baud_selector` mid-frame is unsupported. The frame may report `framing_err`, but the FSM must still return to IDLE.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Adds the PARITY state, `parity_odd` and `parity_err`.
  - Frame is start, data, parity, stop.
  - Expected parity bit = XOR of the data bits, XOR `parity_odd`.
- Not defined: the PARITY state and both ports are absent, and the frame is start, data, stop.

## Structure
- Shared package `uart_pkg`:
  - Receiver state enum: IDLE, START, DATA, PARITY, STOP.
  - Default `SAMPLE` = 16.
  - Baud-select encodings: 0 = 4800, 1 = 9600, 2 = 57600, 3 = 115200.
- Sub-module `uart_sync` (2-FF synchronizer with a reset-value parameter), instantiated for `rx` and `baud_clk`.

## Test plan
All scenarios run at `SysClk` = 50 MHz, 9600 baud, DIVISOR 325, so one tick is 325 cycles and one bit is 5200 cycles.
- Reset: hold `rst` = 0 with `rx` = 1 → all outputs 0. Assert reset mid-frame → IDLE, no `rx_valid`.
- Good frame: send 0xA5, stop bit 1 → `rx_data` = 0xA5, `rx_valid` = 1, no flags. `rx_read` → `rx_valid` = 0.
- Glitch: `rx` low for 3 ticks then high → FSM returns to IDLE and `rx_valid` stays 0.
- Framing error: send 0x3C with stop bit 0 → `rx_data` = 0x3C, `framing_err` = 1.
- Overrun: send 0x11 then 0x22 without `rx_read` → `rx_data` = 0x22, `overrun_err` = 1. Repeat with `rx_read` pulsed in the completion cycle → `overrun_err` = 0.
- Parity (macro defined, `parity_odd` = 0): 0x07 with parity bit 1 → `parity_err` = 0; with parity bit 0 → `parity_err` = 1.
